// File: rtl/nibble_serial_addsub_if.sv
// rtl/nibble_serial_addsub_if.sv - operand/result handshake bundle for the nibble-serial adder
interface nibble_serial_addsub_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  // Operand side
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;

  // Result side
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  // Status
  logic         busy;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, busy
  );
endinterface

// File: rtl/nibble_serial_addsub.sv
// rtl/nibble_serial_addsub.sv - serial add/subtract processing one 4-bit slice per clock
module nibble_serial_addsub #(
  parameter int NIBBLES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  nibble_serial_addsub_if.slave   bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;

  // Captured operands shift right one slice per RUN edge so slice 0 is always
  // the one being processed; the result shifts in from the top so that after
  // NIBBLES steps the first slice computed sits at bit 0.
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic          r_sub;
  logic          r_carry;
  logic          r_cout;
  logic          r_ovf;
  logic [CW-1:0] r_cnt;

  logic          w_accept;
  logic          w_step;
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_busy;
  logic          w_last;
  logic [3:0]    w_bx;
  logic [4:0]    w_slice;
  logic [3:0]    w_low;

  // Subtraction is A + ~B + 1: the inverted B slice here, the +1 via the carry
  // register loaded with Sub at accept time.
  assign w_bx    = r_b[3:0] ^ {4{r_sub}};
  assign w_slice = {1'b0, r_a[3:0]} + {1'b0, w_bx} + {4'b0, r_carry};
  // Carry into bit 3 of the slice; on the top slice this is the carry into the sign bit.
  assign w_low   = {1'b0, r_a[2:0]} + {1'b0, w_bx[2:0]} + {3'b0, r_carry};
  assign w_last  = (r_cnt == LAST);

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state and handshake outputs
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        w_step = 1'b1;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        // Returning to IDLE only; a new accept happens on a later edge.
        if (bus.out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand capture and per-slice arithmetic; nothing moves in IDLE-wait or DONE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_sub   <= bus.sub;
      r_carry <= bus.sub;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a     <= {4'b0, r_a[W-1:4]};
      r_b     <= {4'b0, r_b[W-1:4]};
      r_sum   <= {w_slice[3:0], r_sum[W-1:4]};
      r_carry <= w_slice[4];
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_cout <= w_slice[4];
        r_ovf  <= w_low[3] ^ w_slice[4];
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.sum       = r_sum;
  assign bus.carry_out = r_cout;
  assign bus.overflow  = r_ovf;

endmodule
